router_pkt_tx: RTL and testbench

// Packet source for the 1x3 router input port: the transmit end of the pkt_valid/data_in/busy/err

---
 rtl/router_pkt_tx.sv | 131 +++++++++++++
 tb/tb_router_pkt_tx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers a local payload, then sends header, payload and XOR parity to the router
module router_pkt_tx #(
  parameter int MAX_LEN = 63
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [1:0] i_dest_addr,
  input  logic [5:0] i_pay_len,
  input  logic       i_s_valid,
  input  logic [7:0] i_s_data,
  output logic       o_s_ready,
  input  logic       i_abort,
  input  logic       i_busy,
  input  logic       i_err,
  output logic       o_pkt_valid,
  output logic [7:0] o_data_out,
  output logic       o_tx_busy,
  output logic       o_cmd_err,
  output logic       o_done,
  output logic       o_tx_err
);
  typedef enum logic [2:0] {IDLE, COLLECT, HEADER, PAYLOAD, PARITY, ERR_WAIT} state_t;
  state_t      r_state;
  logic [7:0]  r_buf [MAX_LEN];
  logic [5:0]  r_len, r_wr_ptr, r_rd_ptr;
  logic [1:0]  r_addr;
  logic [7:0]  r_parity, r_data_out;
  logic        r_s_ready, r_pkt_valid, r_cmd_err, r_done, r_tx_err, r_cnt;
  logic        w_take, w_acc, w_last_wr, w_last_rd;
  logic [7:0]  w_rd_next;
  assign w_take    = !i_busy;
  assign w_acc     = r_s_ready && i_s_valid;
  assign w_last_wr = r_wr_ptr == r_len - 6'd1;
  assign w_last_rd = r_rd_ptr == r_len - 6'd1;
  assign w_rd_next = r_buf[r_rd_ptr + 6'd1];
  assign o_s_ready   = r_s_ready;
  assign o_pkt_valid = r_pkt_valid;
  assign o_data_out  = r_data_out;
  assign o_tx_busy   = r_state != IDLE;
  assign o_cmd_err   = r_cmd_err;
  assign o_done      = r_done;
  assign o_tx_err    = r_tx_err;
  // payload buffer, not reset; written only while collecting
  always_ff @(posedge i_clock)
    if (r_state == COLLECT && w_acc) r_buf[r_wr_ptr] <= i_s_data;
  // packet FSM; data_out is preloaded so each byte is ready the cycle its state begins
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_addr      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_parity    <= '0;
      r_data_out  <= '0;
      r_s_ready   <= 1'b0;
      r_pkt_valid <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_done      <= 1'b0;
      r_tx_err    <= 1'b0;
      r_cnt       <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;
      r_done    <= 1'b0;
      if (r_state != IDLE && i_abort) begin
        r_state     <= IDLE;
        r_pkt_valid <= 1'b0;
        r_data_out  <= '0;
        r_s_ready   <= 1'b0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_parity    <= '0;
      end else
        case (r_state)
          IDLE:
            if (i_start) begin
              if (i_pay_len != 6'd0 && i_dest_addr != 2'd3) begin
                r_len     <= i_pay_len;
                r_addr    <= i_dest_addr;
                r_tx_err  <= 1'b0;
                r_wr_ptr  <= '0;
                r_s_ready <= 1'b1;
                r_state   <= COLLECT;
              end else r_cmd_err <= 1'b1;
            end
          COLLECT:
            if (w_acc) begin
              r_wr_ptr <= r_wr_ptr + 6'd1;
              if (w_last_wr) begin
                r_s_ready   <= 1'b0;
                r_pkt_valid <= 1'b1;
                r_data_out  <= {r_len, r_addr};
                r_state     <= HEADER;
              end
            end
          HEADER:
            if (w_take) begin
              r_parity   <= r_data_out;
              r_rd_ptr   <= '0;
              r_data_out <= r_buf[0];
              r_state    <= PAYLOAD;
            end
          PAYLOAD:
            if (w_take) begin
              r_parity <= r_parity ^ r_data_out;
              r_rd_ptr <= r_rd_ptr + 6'd1;
              if (w_last_rd) begin
                r_pkt_valid <= 1'b0;
                r_data_out  <= r_parity ^ r_data_out;
                r_state     <= PARITY;
              end else r_data_out <= w_rd_next;
            end
          PARITY:
            if (w_take) begin
              r_data_out <= '0;
              r_cnt      <= 1'b0;
              r_state    <= ERR_WAIT;
            end
          ERR_WAIT: begin
            r_tx_err <= r_tx_err | i_err;
            r_cnt    <= 1'b1;
            if (r_cnt) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: directed scoreboard bench for router_pkt_tx
module tb_router_pkt_tx;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0] dest = '0;
  logic [5:0] plen = '0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready, abort = 1'b0, busy = 1'b0, err = 1'b0;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_busy, cmd_err, done, tx_err;
  int         n_tests = 0, n_fail = 0;
  logic [8:0] q[$];
  logic [7:0] pay[64];

  always #5 clk = ~clk;

  router_pkt_tx dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_dest_addr(dest), .i_pay_len(plen),
    .i_s_valid(s_valid), .i_s_data(s_data), .o_s_ready(s_ready), .i_abort(abort),
    .i_busy(busy), .i_err(err), .o_pkt_valid(pkt_valid), .o_data_out(data_out),
    .o_tx_busy(tx_busy), .o_cmd_err(cmd_err), .o_done(done), .o_tx_err(tx_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] a, input logic [5:0] n, input bit gaps);
    logic [7:0] p;
    int i = 0, guard = 0;
    bit rdy;
    p = {n, a};
    q.delete();
    q.push_back({1'b1, p});
    for (int k = 0; k < int'(n); k++) begin
      q.push_back({1'b1, pay[k]});
      p ^= pay[k];
    end
    q.push_back({1'b0, p});
    start = 1'b1; dest = a; plen = n;
    @(negedge clk);
    start = 1'b0;
    chk("tx_err_clr", tx_err, 0);
    chk("tx_busy_up", tx_busy, 1);
    while (i < int'(n) && guard < 400) begin
      s_valid = !(gaps && guard % 4 == 1);
      s_data = pay[i];
      rdy = s_ready && s_valid;
      @(negedge clk);
      if (rdy) i++;
      guard++;
    end
    s_valid = 1'b0;
    chk("stream_done", i, n);
  endtask

  task automatic recv(input int si, input int sl, input int ai);
    int i = 0;
    logic [8:0] e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("byte%0d", i), {pkt_valid, data_out}, e);
      if (i == ai) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        q.delete();
        chk("abort_pv", pkt_valid, 0);
        chk("abort_busy", tx_busy, 0);
        chk("abort_do", data_out, 0);
        return;
      end
      if (i == si) begin
        busy = 1'b1;
        repeat (sl) begin
          @(negedge clk);
          chk($sformatf("hold%0d", i), {pkt_valid, data_out}, e);
        end
        busy = 1'b0;
      end
      @(negedge clk);
      i++;
    end
  endtask

  task automatic finish_pkt(input logic exp_err);
    int k = 0;
    chk("ew_pv", pkt_valid, 0);
    chk("ew_do", data_out, 0);
    while (!done && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk("done_lat", k, 2);
    chk("tx_err", tx_err, exp_err);
    chk("idle", tx_busy, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("tx_err_hold", tx_err, exp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_pv", pkt_valid, 0);
    chk("rst_do", data_out, 0);
    chk("rst_srdy", s_ready, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_cmderr", cmd_err, 0);
    chk("rst_done", done, 0);
    chk("rst_txerr", tx_err, 0);
    rst = 1'b0;
    @(negedge clk);
    // basic packet
    pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
    send(2'd1, 6'd3, 1'b0);
    recv(-1, 0, -1);
    finish_pkt(1'b0);
    // busy stall on B2
    send(2'd1, 6'd3, 1'b0);
    recv(2, 4, -1);
    finish_pkt(1'b0);
    // illegal commands
    start = 1'b1; dest = 2'd1; plen = 6'd0;
    @(negedge clk);
    start = 1'b0;
    chk("len0_cmderr", cmd_err, 1);
    chk("len0_busy", tx_busy, 0);
    chk("len0_pv", pkt_valid, 0);
    @(negedge clk);
    chk("cmderr_pulse", cmd_err, 0);
    start = 1'b1; dest = 2'd3; plen = 6'd5;
    @(negedge clk);
    start = 1'b0;
    chk("addr3_cmderr", cmd_err, 1);
    chk("addr3_busy", tx_busy, 0);
    @(negedge clk);
    chk("addr3_pv", pkt_valid, 0);
    // max length with stream gaps
    for (int k = 0; k < 63; k++) pay[k] = 8'(k);
    send(2'd2, 6'd63, 1'b1);
    recv(-1, 0, -1);
    finish_pkt(1'b0);
    // router parity error
    pay[0] = 8'h5A; pay[1] = 8'h3C;
    send(2'd0, 6'd2, 1'b0);
    recv(-1, 0, -1);
    err = 1'b1;
    finish_pkt(1'b1);
    err = 1'b0;
    // abort mid-payload; send also checks tx_err cleared by start
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    send(2'd2, 6'd4, 1'b0);
    recv(-1, 0, 2);
    repeat (4) begin
      @(negedge clk);
      chk("abort_nodone", done, 0);
    end
    // async reset while header presented
    send(2'd1, 6'd3, 1'b0);
    chk("hdr_pv", pkt_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_pv", pkt_valid, 0);
    chk("arst_busy", tx_busy, 0);
    chk("arst_do", data_out, 0);
    #1 rst = 1'b0;
    q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("arst_nodone", done, 0);
    end
    // recovery packet
    pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
    send(2'd1, 6'd3, 1'b0);
    recv(-1, 0, -1);
    finish_pkt(1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
